// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_if
//  Description : Decode-to-execute operand bus. ID drives the decoded
//                instruction and its valid flag. EX returns es_allowin and
//                latches the bus when both valid and allowin are high.
//                master : ID side (drives decode outputs, reads es_allowin)
//                slave  : EX side (reads decode outputs, drives es_allowin)
//  Revision    : 1.0  initial release
// ============================================================================
interface id_stage_if;
   logic        ds_to_es_valid;
   logic        es_allowin;
   logic [31:0] ds_pc;
   logic [11:0] ds_alu_op;
   logic [31:0] ds_alu_src1;
   logic [31:0] ds_alu_src2;
   logic [4:0]  ds_dest;
   logic        ds_gr_we;

   modport master (
      output ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2,
             ds_dest, ds_gr_we,
      input  es_allowin
   );

   modport slave (
      input  ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2,
             ds_dest, ds_gr_we,
      output es_allowin
   );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : LA32R decode stage. Holds the IF/ID register, reads the
//                register file, and decodes the instruction into a one-hot
//                ALU control and two ALU operands. RAW hazards against
//                in-flight EX/MEM/WB writes stall the stage. No forwarding.
//  Ports       : clk, reset              clock, synchronous active-high reset
//                fs_to_ds_valid/fs_pc/fs_inst  instruction offered by IF
//                ds_allowin              stage can accept an instruction
//                ds_es (master)          decoded bus towards EX
//                rf_raddr1/2, rf_rdata1/2  asynchronous register-file read
//                {es,ms,ws}_wr_valid/_dest  in-flight register writes
//  Revision    : 1.0  initial release
// ============================================================================
module id_stage (
   input  wire              clk,
   input  wire              reset,
   input  wire              fs_to_ds_valid,
   input  wire  [31:0]      fs_pc,
   input  wire  [31:0]      fs_inst,
   output logic             ds_allowin,
   id_stage_if.master       ds_es,
   output logic [4:0]       rf_raddr1,
   output logic [4:0]       rf_raddr2,
   input  wire  [31:0]      rf_rdata1,
   input  wire  [31:0]      rf_rdata2,
   input  wire              es_wr_valid,
   input  wire  [4:0]       es_wr_dest,
   input  wire              ms_wr_valid,
   input  wire  [4:0]       ms_wr_dest,
   input  wire              ws_wr_valid,
   input  wire  [4:0]       ws_wr_dest
);

   // 3R and shift-immediate opcodes, matched on inst[31:15]
   localparam logic [16:0] c_op_add_w  = 17'h00020;
   localparam logic [16:0] c_op_sub_w  = 17'h00022;
   localparam logic [16:0] c_op_slt    = 17'h00024;
   localparam logic [16:0] c_op_sltu   = 17'h00025;
   localparam logic [16:0] c_op_nor    = 17'h00028;
   localparam logic [16:0] c_op_and    = 17'h00029;
   localparam logic [16:0] c_op_or     = 17'h0002A;
   localparam logic [16:0] c_op_xor    = 17'h0002B;
   localparam logic [16:0] c_op_sll_w  = 17'h0002E;
   localparam logic [16:0] c_op_srl_w  = 17'h0002F;
   localparam logic [16:0] c_op_sra_w  = 17'h00030;
   localparam logic [16:0] c_op_slli_w = 17'h00081;
   localparam logic [16:0] c_op_srli_w = 17'h00089;
   localparam logic [16:0] c_op_srai_w = 17'h00091;
   // 2RI12 opcodes, matched on inst[31:22]
   localparam logic [9:0]  c_op_slti   = 10'h008;
   localparam logic [9:0]  c_op_sltui  = 10'h009;
   localparam logic [9:0]  c_op_addi_w = 10'h00A;
   localparam logic [9:0]  c_op_andi   = 10'h00D;
   localparam logic [9:0]  c_op_ori    = 10'h00E;
   localparam logic [9:0]  c_op_xori   = 10'h00F;
   // 1RI20 opcode, matched on inst[31:25]
   localparam logic [6:0]  c_op_lu12i_w = 7'h0A;

   // ------------------------------------------------------------------
   // IF/ID pipeline register
   // ------------------------------------------------------------------
   logic        r_ds_valid;
   logic [31:0] r_ds_pc;
   logic [31:0] r_ds_inst;

   logic        w_hazard;
   logic        w_ds_ready_go;

   assign w_ds_ready_go        = ~w_hazard;
   assign ds_allowin           = ~r_ds_valid | (w_ds_ready_go & ds_es.es_allowin);
   assign ds_es.ds_to_es_valid = r_ds_valid & w_ds_ready_go;

   // Loading while the stage is allowed in covers both the empty case and
   // the leave-and-replace case, so a stream flows with no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ds_valid <= 1'b0;
         r_ds_pc    <= 32'b0;
         r_ds_inst  <= 32'b0;
      end else if (ds_allowin) begin
         r_ds_valid <= fs_to_ds_valid;
         if (fs_to_ds_valid) begin
            r_ds_pc   <= fs_pc;
            r_ds_inst <= fs_inst;
         end
      end
   end

   // ------------------------------------------------------------------
   // Field extraction
   // ------------------------------------------------------------------
   logic [16:0] w_op17;
   logic [9:0]  w_op10;
   logic [6:0]  w_op7;
   logic [4:0]  w_rd;
   logic [4:0]  w_rj;
   logic [4:0]  w_rk;
   logic [11:0] w_i12;
   logic [19:0] w_i20;

   assign w_op17 = r_ds_inst[31:15];
   assign w_op10 = r_ds_inst[31:22];
   assign w_op7  = r_ds_inst[31:25];
   assign w_rd   = r_ds_inst[4:0];
   assign w_rj   = r_ds_inst[9:5];
   assign w_rk   = r_ds_inst[14:10];   // doubles as ui5 for shift-immediate
   assign w_i12  = r_ds_inst[21:10];
   assign w_i20  = r_ds_inst[24:5];

   assign rf_raddr1 = w_rj;
   assign rf_raddr2 = w_rk;

   // ------------------------------------------------------------------
   // Opcode decode
   // ------------------------------------------------------------------
   logic w_add, w_sub, w_slt, w_sltu, w_nor, w_and, w_or, w_xor;
   logic w_sll, w_srl, w_sra, w_slli, w_srli, w_srai;
   logic w_slti, w_sltui, w_addi, w_andi, w_ori, w_xori, w_lu12i;

   assign w_add   = (w_op17 == c_op_add_w);
   assign w_sub   = (w_op17 == c_op_sub_w);
   assign w_slt   = (w_op17 == c_op_slt);
   assign w_sltu  = (w_op17 == c_op_sltu);
   assign w_nor   = (w_op17 == c_op_nor);
   assign w_and   = (w_op17 == c_op_and);
   assign w_or    = (w_op17 == c_op_or);
   assign w_xor   = (w_op17 == c_op_xor);
   assign w_sll   = (w_op17 == c_op_sll_w);
   assign w_srl   = (w_op17 == c_op_srl_w);
   assign w_sra   = (w_op17 == c_op_sra_w);
   assign w_slli  = (w_op17 == c_op_slli_w);
   assign w_srli  = (w_op17 == c_op_srli_w);
   assign w_srai  = (w_op17 == c_op_srai_w);
   assign w_slti  = (w_op10 == c_op_slti);
   assign w_sltui = (w_op10 == c_op_sltui);
   assign w_addi  = (w_op10 == c_op_addi_w);
   assign w_andi  = (w_op10 == c_op_andi);
   assign w_ori   = (w_op10 == c_op_ori);
   assign w_xori  = (w_op10 == c_op_xori);
   assign w_lu12i = (w_op7  == c_op_lu12i_w);

   logic w_is_shift_3r, w_is_3r, w_is_shift_imm, w_is_imm_sext, w_is_imm_zext;
   logic w_valid_op, w_reads_rj, w_reads_rk;

   assign w_is_shift_3r  = w_sll | w_srl | w_sra;
   assign w_is_3r        = w_add | w_sub | w_slt | w_sltu | w_nor | w_and |
                           w_or | w_xor | w_is_shift_3r;
   assign w_is_shift_imm = w_slli | w_srli | w_srai;
   assign w_is_imm_sext  = w_addi | w_slti | w_sltui;
   assign w_is_imm_zext  = w_andi | w_ori | w_xori;
   assign w_valid_op     = w_is_3r | w_is_shift_imm | w_is_imm_sext |
                           w_is_imm_zext | w_lu12i;
   // Every recognised class reads rj except lu12i.w, whose inst[9:5]
   // are immediate bits and must not create false hazards.
   assign w_reads_rj     = w_valid_op & ~w_lu12i;
   assign w_reads_rk     = w_is_3r;

   assign ds_es.ds_alu_op = {w_lu12i,
                             w_sra | w_srai,
                             w_srl | w_srli,
                             w_sll | w_slli,
                             w_xor | w_xori,
                             w_or  | w_ori,
                             w_nor,
                             w_and | w_andi,
                             w_sltu | w_sltui,
                             w_slt | w_slti,
                             w_sub,
                             w_add | w_addi};

   assign ds_es.ds_pc    = r_ds_pc;
   assign ds_es.ds_dest  = w_rd;
   assign ds_es.ds_gr_we = w_valid_op & (w_rd != 5'd0);

   // ------------------------------------------------------------------
   // Operand selection. The ALU shifts src2 by src1[4:0], so shifts put
   // the amount in src1 and the value being shifted in src2.
   // ------------------------------------------------------------------
   logic [31:0] w_src1;
   logic [31:0] w_src2;

   always_comb begin
      w_src1 = rf_rdata1;
      w_src2 = rf_rdata2;
      if (w_is_shift_3r) begin
         w_src1 = rf_rdata2;
         w_src2 = rf_rdata1;
      end else if (w_is_shift_imm) begin
         w_src1 = {27'b0, w_rk};
         w_src2 = rf_rdata1;
      end else if (w_is_imm_sext) begin
         w_src2 = {{20{w_i12[11]}}, w_i12};
      end else if (w_is_imm_zext) begin
         w_src2 = {20'b0, w_i12};
      end else if (w_lu12i) begin
         w_src1 = 32'b0;
         w_src2 = {w_i20, 12'b0};
      end
   end

   assign ds_es.ds_alu_src1 = w_src1;
   assign ds_es.ds_alu_src2 = w_src2;

   // ------------------------------------------------------------------
   // RAW hazard detection. WB matches stall as well because the register
   // file does not bypass a write into a read in the same cycle.
   // ------------------------------------------------------------------
   logic w_hit_es, w_hit_ms, w_hit_ws;

   assign w_hit_es = es_wr_valid & (es_wr_dest != 5'd0) &
                     ((w_reads_rj & (es_wr_dest == w_rj)) |
                      (w_reads_rk & (es_wr_dest == w_rk)));
   assign w_hit_ms = ms_wr_valid & (ms_wr_dest != 5'd0) &
                     ((w_reads_rj & (ms_wr_dest == w_rj)) |
                      (w_reads_rk & (ms_wr_dest == w_rk)));
   assign w_hit_ws = ws_wr_valid & (ws_wr_dest != 5'd0) &
                     ((w_reads_rj & (ws_wr_dest == w_rj)) |
                      (w_reads_rk & (ws_wr_dest == w_rk)));

   assign w_hazard = r_ds_valid & (w_hit_es | w_hit_ms | w_hit_ws);

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Decode stage of the 5-stage LA32R pipeline. It holds the IF/ID pipeline register, reads the register file, and decodes the 32-bit instruction word into the 12-bit one-hot ALU control and the two ALU operands. Read-after-write (RAW) hazards against in-flight EX/MEM/WB writes are handled by stalling; there is no forwarding. It is the producing end of the ALU operand interface: EX latches its outputs and drives the ALU directly.

## Interface
Parameters:
- none; widths are fixed by LA32R.

Ports:
- clk  in  1  sole clock; everything samples on the rising edge.
- reset  in  1  synchronous, active-high.
- fs_to_ds_valid  in  1  IF is offering an instruction.
- fs_pc  in  32  PC of the offered instruction.
- fs_inst  in  32  offered instruction word.
- ds_allowin  out  1  this stage can accept a new instruction this cycle.
- es_allowin  in  1  EX will latch the decode outputs this cycle.
- ds_to_es_valid  out  1  decoded instruction is valid and free of hazards.
- ds_pc  out  32  registered PC.
- ds_alu_op  out  12  one-hot ALU control: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui.
- ds_alu_src1  out  32  ALU operand 1.
- ds_alu_src2  out  32  ALU operand 2.
- ds_dest  out  5  destination register number (rd).
- ds_gr_we  out  1  instruction writes the register file.
- rf_raddr1, rf_raddr2  out  5  register file read addresses (asynchronous read).
- rf_rdata1, rf_rdata2  in  32  register file read data.
- es_wr_valid / es_wr_dest  in  1 / 5  EX holds a valid instruction that writes this register.
- ms_wr_valid / ms_wr_dest  in  1 / 5  same, for MEM.
- ws_wr_valid / ws_wr_dest  in  1 / 5  same, for WB.

## Operation
- Registers: ds_valid, ds_pc, ds_inst. On reset all three clear to 0.
- Capture: when fs_to_ds_valid & ds_allowin, load fs_pc and fs_inst, and set ds_valid=1. When ds_allowin=1 and fs_to_ds_valid=0, clear ds_valid.
- ds_ready_go = ~hazard.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
- ds_to_es_valid = ds_valid & ds_ready_go.
- Read ports: rf_raddr1 = rj (inst[9:5]). rf_raddr2 = rk (inst[14:10]).
- Decode classes and opcode match fields:
  - 3R, match inst[31:15]: add.w 0x20, sub.w 0x22, slt 0x24, sltu 0x25, nor 0x28, and 0x29, or 0x2A, xor 0x2B, sll.w 0x2E, srl.w 0x2F, sra.w 0x30.
  - Shift-immediate, match inst[31:15]: slli.w 0x81, srli.w 0x89, srai.w 0x91.
  - 2RI12, match inst[31:22]: slti 0x008, sltui 0x009, addi.w 0x00A, andi 0x00D, ori 0x00E, xori 0x00F.
  - 1RI20, match inst[31:25]: lu12i.w 0x0A.
- Operand rules (the ALU computes src1−src2, src1<src2, and src2 shifted by src1[4:0]):
  - 3R arithmetic, compare and logical ops: src1 = rj value, src2 = rk value.
  - 3R shifts: src1 = rk value, src2 = rj value.
  - Shift-immediate: src1 = {27'b0, ui5}, src2 = rj value.
  - addi, slti, sltui: src2 = sign-extended si12.
  - andi, ori, xori: src2 = zero-extended ui12.
  - lu12i.w: src2 = {si20, 12'b0}, src1 = 0.
- ds_gr_we = valid_opcode & (rd != 0).
- Unrecognised opcode: ds_alu_op = 0 and ds_gr_we = 0. The instruction still flows as a bubble-equivalent NOP.
- Hazard, for x ∈ {es, ms, ws}, when x_wr_valid & x_wr_dest != 0:
  - rj matches x_wr_dest, and the instruction reads rj. All recognised classes except lu12i.w read rj.
  - rk matches x_wr_dest, and the instruction is 3R.
- WB match stalls too. The register file does not bypass same-cycle writes.

## Timing
- Reset values: ds_valid=0, ds_to_es_valid=0, ds_allowin=1, ds_pc=0. ds_inst=0 decodes as invalid, so ds_alu_op=0 and ds_gr_we=0.
- Latency: an instruction captured at edge N presents its decode outputs combinationally throughout cycle N+1.
- Stall: while hazard=1, ds_to_es_valid=0, ds_allowin=0, and ds_pc/ds_inst hold.
  - It leaves at the first cycle in which no in-flight write matches.
- Back-pressure: if es_allowin=0, the stage holds even without a hazard, and ds_allowin=0.
- Simultaneous capture and leave: when ds_valid=1 and the instruction leaves while a new one arrives, the new one replaces it at the same edge with no bubble. Full throughput is 1 instruction/cycle.
- Reset during a stall discards the held instruction.

## Test plan
- Back-to-back independent stream:
  - Stimulus: addi.w r1,r0,5 then addi.w r2,r0,−1, es_allowin=1.
  - Required response: ds_alu_op=0x001 each cycle. src2=0x00000005, then 0xFFFFFFFF. No bubbles.
- Shift operand swap:
  - Stimulus: sll.w r3,r4,r5 with rf r4=0x1, r5=0x4.
  - Required response: src1=0x4, src2=0x1, op=0x100. slli.w r3,r4,31 gives src1=0x1F.
- Immediate extension:
  - Stimulus: ori r1,r0,0xFFF.
  - Required response: src2=0x00000FFF, op=0x040. lu12i.w r1,0x80000 gives src2=0x80000000, op=0x800.
- RAW stall:
  - Stimulus: es_wr_valid=1 with es_wr_dest=7, then ms, then ws, for add.w r8,r7,r9.
  - Required response: 3 stall cycles with ds_allowin=0, then release. Dest 0 never stalls.
- Back-pressure:
  - Stimulus: es_allowin=0 for 2 cycles.
  - Required response: outputs stable, ds_allowin=0.
- Illegal opcode and reset mid-stall:
  - Stimulus: illegal word 0xFFFFFFFF; separately, reset asserted while stalled.
  - Required response: illegal word gives op=0, gr_we=0. Reset gives ds_valid=0 next cycle.
- rd = 0:
  - Stimulus: add.w r0,r1,r2.
  - Required response: gr_we=0.
